// File: rtl/bs_gnrtr_n_rbtr_pkg.sv
// bs_pkg: shared FSM state type, header ID width and ID extraction helper for the bus generator/arbiter.
package bs_pkg;
    typedef enum logic [1:0] {IDLE, POP, PUSH} state_e;
    localparam int ID_W = 8;
    localparam int PKT_MAX = 256;
    function automatic logic [ID_W-1:0] id_of(input logic [PKT_MAX-1:0] pkt, input int sz);
        return pkt[sz-1 -: ID_W];
    endfunction
endpackage

// File: rtl/bs_gnrtr_n_rbtr_rr_arbiter.sv
// rr_arbiter: round-robin grant, searching last+1, last+2, ... modulo N for the first requester.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        idx = last;
        any = 1'b0;
        // Walk the ring backwards so the nearest requester after last is assigned last and wins.
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last) + i) % N]) begin
                idx = IW'((int'(last) + i) % N);
                any = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) gnt[k] = any && (int'(idx) == k);
    end
endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// bs_gnrtr_n_rbtr: per-bus round-robin arbiter moving one packet per 3 cycles from terminal FIFOs to unicast/broadcast targets.
// Define BRDCST_SELF_EN to make broadcasts also push back to the sending terminal.
module bs_gnrtr_n_rbtr import bs_pkg::*; #(
    parameter int bits = 1,
    parameter int drvrs = 4,
    parameter int pckg_sz = 16,
    parameter logic [ID_W-1:0] broadcast = {ID_W{1'b1}}
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [bits-1:0][drvrs-1:0]              pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]              pop,
    output logic [bits-1:0][drvrs-1:0]              push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);
    localparam int IW = drvrs > 1 ? $clog2(drvrs) : 1;
`ifdef BRDCST_SELF_EN
    localparam bit BC_SELF = 1'b1;
`else
    localparam bit BC_SELF = 1'b0;
`endif

    for (genvar b = 0; b < bits; b++) begin : g_bus
        state_e             state_q, state_d;
        logic [IW-1:0]      src_q, src_d, last_q, last_d, idx;
        logic [pckg_sz-1:0] pkt_q, pkt_d, head;
        logic [drvrs-1:0]   pop_q, pop_d, push_q, push_d, gnt;
        logic [ID_W-1:0]    id;
        logic               any;

        rr_arbiter #(.N(drvrs)) u_arb (.req(pndng[b]), .last(last_q), .gnt(gnt), .idx(idx), .any(any));

        assign head = D_pop[b][src_q];
        assign id   = id_of(PKT_MAX'(head), pckg_sz);

        // Push targets are decoded from the head word while popping so push is a registered pulse in PUSH.
        always_comb begin
            state_d = state_q;
            src_d   = src_q;
            last_d  = last_q;
            pkt_d   = pkt_q;
            pop_d   = '0;
            push_d  = '0;
            case (state_q)
                IDLE: if (any) begin
                    src_d   = idx;
                    last_d  = idx;
                    pop_d   = gnt;
                    state_d = POP;
                end
                POP: begin
                    pkt_d   = head;
                    state_d = PUSH;
                    for (int j = 0; j < drvrs; j++)
                        push_d[j] = (id == broadcast) ? (BC_SELF || j != int'(src_q)) : (int'(id) == j);
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                src_q   <= '0;
                last_q  <= IW'(drvrs - 1);
                pkt_q   <= '0;
                pop_q   <= '0;
                push_q  <= '0;
            end else begin
                state_q <= state_d;
                src_q   <= src_d;
                last_q  <= last_d;
                pkt_q   <= pkt_d;
                pop_q   <= pop_d;
                push_q  <= push_d;
            end
        end

        assign pop[b]    = pop_q;
        assign push[b]   = push_q;
        assign D_push[b] = {drvrs{pkt_q}};
    end
endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// tb_bs_gnrtr_n_rbtr: scoreboard bench; terminal FIFO model drives pndng/D_pop, monitor checks every pop/push pulse.
module tb_bs_gnrtr_n_rbtr;
    localparam int B = 1, N = 4, W = 24;
`ifdef BRDCST_SELF_EN
    localparam logic [N-1:0] BC_MASK = 4'b1111;
`else
    localparam logic [N-1:0] BC_MASK = 4'b1011;
`endif

    typedef struct {
        int           cyc;
        bit           is_push;
        logic [N-1:0] mask;
        logic [W-1:0] data;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1;
    logic [B-1:0][N-1:0]        pndng, pop, push;
    logic [B-1:0][N-1:0][W-1:0] D_pop, D_push;

    exp_t         q[$];
    logic [W-1:0] fifo[N][$];
    logic [N-1:0] ps = '0;
    int           cyc = 0, n_cmp = 0, n_bad = 0, c0;
    bit           rst_chk = 1'b0, fin = 1'b0, fin_done = 1'b0;

    bs_gnrtr_n_rbtr #(.bits(B), .drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic expect_ev(input int c, input bit p, input logic [N-1:0] m, input logic [W-1:0] d);
        exp_t e;
        e.cyc = c;
        e.is_push = p;
        e.mask = m;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic drive();
        for (int j = 0; j < N; j++) begin
            pndng[0][j] = fifo[j].size() != 0;
            D_pop[0][j] = fifo[j].size() != 0 ? fifo[j][0] : '0;
        end
    endtask

    // One cycle step: retire heads popped last cycle, then capture this cycle's pops.
    task automatic tick();
        @(negedge clk);
        #1;
        for (int j = 0; j < N; j++) if (ps[j] && fifo[j].size() != 0) void'(fifo[j].pop_front());
        ps = pop[0];
        drive();
    endtask

    task automatic xfer(input int t, input logic [W-1:0] d, input logic [N-1:0] pm);
        int c;
        c = cyc;
        fifo[t].push_back(d);
        drive();
        expect_ev(c + 1, 1'b0, 4'(1 << t), '0);
        if (pm != '0) expect_ev(c + 2, 1'b1, pm, d);
        repeat (5) tick();
    endtask

    task automatic sb(input bit is_push, input logic [N-1:0] m);
        exp_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: cycle %0d mask %b, required no event", is_push ? "push" : "pop", cyc, m);
            return;
        end
        e = q.pop_front();
        if (e.is_push != is_push || e.cyc != cyc || e.mask != m || (is_push && D_push[0] != {N{e.data}})) begin
            n_bad++;
            $display("FAIL %s_event: got cycle %0d mask %b data %h, required %s cycle %0d mask %b data %h",
                     is_push ? "push" : "pop", cyc, m, D_push[0][0], e.is_push ? "push" : "pop", e.cyc, e.mask, e.data);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_chk) begin
            n_cmp++;
            if (pop != '0 || push != '0 || D_push != '0) begin
                n_bad++;
                $display("FAIL reset_quiet: pop %b push %b D_push %h, required all zero", pop[0], push[0], D_push[0]);
            end
        end else begin
            if (pop != '0) sb(1'b0, pop[0]);
            if (push != '0) sb(1'b1, push[0]);
        end
        if (fin && !fin_done) begin
            n_cmp++;
            if (q.size() != 0) begin
                n_bad++;
                $display("FAIL leftover: %0d expected events never seen, required 0", q.size());
            end
            fin_done = 1'b1;
        end
    end

    initial begin
        rst_chk = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int t = 0; t < N; t++) fifo[t].push_back({8'((t + 1) % N), 8'(t), 8'(k)});
        drive();
        repeat (3) tick();
        c0 = cyc;
        for (int k = 0; k < 2 * N; k++) begin
            expect_ev(c0 + 1 + 3 * k, 1'b0, 4'(1 << (k % N)), '0);
            expect_ev(c0 + 2 + 3 * k, 1'b1, 4'(1 << ((k % N + 1) % N)), {8'((k % N + 1) % N), 8'(k % N), 8'(k / N)});
        end
        reset = 1'b0;
        rst_chk = 1'b0;
        repeat (26) tick();

        xfer(1, 24'h02ABCD, 4'b0100);
        xfer(2, 24'hFF1234, BC_MASK);
        xfer(0, 24'h095555, 4'b0000);
        xfer(1, 24'h040001, 4'b0000);
        xfer(3, 24'h037777, 4'b1000);

        c0 = cyc;
        fifo[1].push_back(24'h02BEEF);
        drive();
        expect_ev(c0 + 1, 1'b0, 4'b0010, '0);
        tick();
        reset = 1'b1;
        rst_chk = 1'b1;
        tick();
        reset = 1'b0;
        rst_chk = 1'b0;
        repeat (4) tick();

        c0 = cyc;
        fifo[3].push_back(24'h022222);
        fifo[0].push_back(24'h011111);
        drive();
        expect_ev(c0 + 1, 1'b0, 4'b0001, '0);
        expect_ev(c0 + 2, 1'b1, 4'b0010, 24'h011111);
        expect_ev(c0 + 4, 1'b0, 4'b1000, '0);
        expect_ev(c0 + 5, 1'b1, 4'b0100, 24'h022222);
        repeat (8) tick();

        fin = 1'b1;
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
